unified_mem_arbiter: RTL and testbench

- Shares one single-port unified instruction/data memory between the IF stage (instruction fetch, read-only) and the MEM stage (load/store).
- Sequences each access as issue → wait-for-ready → respond.
- Enforces MEM-stage priority with a fairness bound so IF is never starved.
- Produces per-requester stall signals that the pipeline uses to freeze IF/ID and EX/MEM.

---
 rtl/unified_mem_arbiter_pkg.sv | 25 ++
 rtl/unified_mem_arbiter_if.sv | 55 +++++
 rtl/unified_mem_arbiter_wait_timer.sv | 40 ++++
 rtl/unified_mem_arbiter.sv | 169 ++++++++++++++++
 tb/tb_unified_mem_arbiter.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/unified_mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : unified_mem_arbiter_pkg
//  Description : Shared types and constants for the unified memory arbiter.
//                Provides the arbiter state encoding, the owner encoding and
//                the default read data returned when an access times out.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package unified_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_DM = 1'b1;

  localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEADBEEF;

endpackage
`default_nettype wire

// File: rtl/unified_mem_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : unified_mem_arbiter_if
//  Description : Bundles the fetch port, the data port, the memory port and
//                the error flag of the unified memory arbiter.
//  Modports    : slave  - arbiter view (takes requests, drives memory)
//                master - environment view (pipeline stages + memory)
//  Revision    : 1.0 - initial release
// ============================================================================
interface unified_mem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);

  // Instruction fetch port
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          if_ack;
  logic          if_stall;

  // Data (load/store) port
  logic          dm_req;
  logic          dm_we;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata;
  logic [DW-1:0] dm_rdata;
  logic          dm_ack;
  logic          dm_stall;

  // Single-port memory
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ready;

  // Sticky timeout flag
  logic          err;

  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata, mem_ready,
    output if_rdata, if_ack, if_stall, dm_rdata, dm_ack, dm_stall,
           mem_en, mem_we, mem_addr, mem_wdata, err
  );

  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata, mem_ready,
    input  if_rdata, if_ack, if_stall, dm_rdata, dm_ack, dm_stall,
           mem_en, mem_we, mem_addr, mem_wdata, err
  );

endinterface
`default_nettype wire

// File: rtl/unified_mem_arbiter_wait_timer.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arb_wait_timer
//  Description : Counts cycles spent waiting for the memory. Flags expiry
//                when the count reaches TIMEOUT-1 and holds there.
//  Ports       : clk, rst     - clock, asynchronous active-high reset
//                clear_i      - restart the count at zero
//                enable_i     - advance the count by one
//                expired_o    - count has reached TIMEOUT-1
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_arb_wait_timer #(
  parameter int TIMEOUT = 16
) (
  input  wire logic clk,
  input  wire logic rst,
  input  wire logic clear_i,
  input  wire logic enable_i,
  output logic      expired_o
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clear_i) begin
      cnt_q <= '0;
    end else if (enable_i && (cnt_q != LAST)) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  assign expired_o = (cnt_q == LAST);

endmodule
`default_nettype wire

// File: rtl/unified_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : unified_mem_arbiter
//  Description : Shares one single-port memory between instruction fetch and
//                the load/store stage. Each access runs IDLE->ISSUE->WAIT->
//                RESP. Data accesses win ties unless FAIR_N consecutive data
//                grants have been made while a fetch was pending. A WAIT
//                lasting TIMEOUT cycles returns ERR_DATA and sets sticky err.
//  Ports       : clk, rst  - clock, asynchronous active-high reset
//                bus       - fetch, data, memory and error signals (slave)
//  Revision    : 1.0 - initial release
// ============================================================================
module unified_mem_arbiter
  import unified_mem_arbiter_pkg::*;
#(
  parameter int            AW       = 32,
  parameter int            DW       = 32,
  parameter int            TIMEOUT  = 16,
  parameter int            FAIR_N   = 4,
  parameter logic [DW-1:0] ERR_DATA = ERR_DATA_DEFAULT
) (
  input wire logic             clk,
  input wire logic             rst,
  unified_mem_arbiter_if.slave bus
);

  localparam int SW = $clog2(FAIR_N + 1);
  localparam logic [SW-1:0] FAIR_MAX = SW'(FAIR_N);

  arb_state_t    state_q, state_d;
  logic          owner_q, owner_d;
  logic [SW-1:0] dm_streak_q, dm_streak_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic [DW-1:0] if_rdata_q, if_rdata_d;
  logic [DW-1:0] dm_rdata_q, dm_rdata_d;
  logic          err_q, err_d;

  logic          timer_clear;
  logic          timer_enable;
  logic          timer_expired;

  mem_arb_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .clk       (clk),
    .rst       (rst),
    .clear_i   (timer_clear),
    .enable_i  (timer_enable),
    .expired_o (timer_expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      owner_q     <= OWN_IF;
      dm_streak_q <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      dm_streak_q <= dm_streak_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    dm_streak_d  = dm_streak_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    if_rdata_d   = if_rdata_q;
    dm_rdata_d   = dm_rdata_q;
    err_d        = err_q;
    timer_clear  = 1'b0;
    timer_enable = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.if_req || bus.dm_req) begin
          state_d = ISSUE;
          // Data wins unless it has already taken FAIR_N grants in a row
          // while a fetch was waiting.
          if (bus.dm_req && !(bus.if_req && (dm_streak_q == FAIR_MAX))) begin
            owner_d     = OWN_DM;
            mem_addr_d  = bus.dm_addr;
            mem_we_d    = bus.dm_we;
            mem_wdata_d = bus.dm_wdata;
            if (!bus.if_req) begin
              dm_streak_d = '0;
            end else if (dm_streak_q != FAIR_MAX) begin
              dm_streak_d = dm_streak_q + SW'(1);
            end
          end else begin
            owner_d     = OWN_IF;
            mem_addr_d  = bus.if_addr;
            mem_we_d    = 1'b0;
            mem_wdata_d = '0;
            dm_streak_d = '0;
          end
        end
      end

      ISSUE: begin
        state_d     = WAIT;
        timer_clear = 1'b1;
      end

      WAIT: begin
        // A ready arriving on the expiry cycle still counts as a response.
        if (bus.mem_ready) begin
          state_d = RESP;
          if (owner_q == OWN_DM) begin
            dm_rdata_d = mem_we_q ? '0 : bus.mem_rdata;
          end else begin
            if_rdata_d = bus.mem_rdata;
          end
        end else if (timer_expired) begin
          state_d = RESP;
          err_d   = 1'b1;
          if (owner_q == OWN_DM) begin
            dm_rdata_d = ERR_DATA;
          end else begin
            if_rdata_d = ERR_DATA;
          end
        end else begin
          timer_enable = 1'b1;
        end
      end

      RESP: begin
        // Requests are deliberately not sampled here so the requester can
        // drop req during its ack cycle.
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.mem_en    = (state_q == ISSUE);
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.if_ack    = (state_q == RESP) && (owner_q == OWN_IF);
  assign bus.dm_ack    = (state_q == RESP) && (owner_q == OWN_DM);
  assign bus.if_rdata  = if_rdata_q;
  assign bus.dm_rdata  = dm_rdata_q;
  assign bus.if_stall  = bus.if_req & ~bus.if_ack;
  assign bus.dm_stall  = bus.dm_req & ~bus.dm_ack;
  assign bus.err       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_unified_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_unified_mem_arbiter
//  Description : Scoreboard bench for unified_mem_arbiter. Stimulus pushes
//                expected memory issues and acks into queues; a monitor pops
//                and compares whenever mem_en or an ack is presented.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_unified_mem_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  unified_mem_arbiter_if #(.AW(32), .DW(32)) bus();

  unified_mem_arbiter #(
    .AW       (32),
    .DW       (32),
    .TIMEOUT  (16),
    .FAIR_N   (4),
    .ERR_DATA (32'hDEADBEEF)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic        dm;
    logic [31:0] data;
  } ack_t;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
  } iss_t;

  ack_t ack_q[$];
  iss_t iss_q[$];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Memory responder controls
  int          resp_delay = 1;
  logic [31:0] resp_data  = 32'h0;
  int          man_at0 = -1, man_at1 = -1;
  logic [31:0] man_dat0 = 32'h0, man_dat1 = 32'h0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memory model: answers mem_en after resp_delay cycles (0 = never), plus
  // up to two hand-placed ready pulses at absolute cycle numbers.
  initial begin
    int cnt;
    cnt = 0;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = 32'h0;
    forever begin
      @(posedge clk);
      #1;
      bus.mem_ready = 1'b0;
      if (cyc == man_at0) begin
        bus.mem_ready = 1'b1;
        bus.mem_rdata = man_dat0;
      end else if (cyc == man_at1) begin
        bus.mem_ready = 1'b1;
        bus.mem_rdata = man_dat1;
      end else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          bus.mem_ready = 1'b1;
          bus.mem_rdata = resp_data;
        end
      end
      if (bus.mem_en && resp_delay > 0) cnt = resp_delay;
    end
  end

  // Monitor / scoreboard
  initial begin
    logic prev_ack;
    logic any_ack;
    iss_t ei;
    ack_t ea;
    prev_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_ack = 1'b0;
      end else begin
        if (bus.mem_en) begin
          if (iss_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_mem_en: got addr %h, expected no access", bus.mem_addr);
          end else begin
            ei = iss_q.pop_front();
            check("mem_addr", bus.mem_addr, ei.addr);
            check("mem_we", {31'h0, bus.mem_we}, {31'h0, ei.we});
            if (ei.we) check("mem_wdata", bus.mem_wdata, ei.wdata);
          end
        end
        any_ack = bus.if_ack | bus.dm_ack;
        checks++;
        if (bus.if_ack && bus.dm_ack) begin
          failures++;
          $display("FAIL ack_exclusive: got if_ack=1 dm_ack=1, expected at most one");
        end
        if (any_ack) begin
          check("ack_gap", {31'h0, prev_ack}, 32'h0);
          if (ack_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_ack: got if_ack=%0b dm_ack=%0b, expected none", bus.if_ack, bus.dm_ack);
          end else begin
            ea = ack_q.pop_front();
            check("ack_owner_dm", {31'h0, bus.dm_ack}, {31'h0, ea.dm});
            check("ack_rdata", ea.dm ? bus.dm_rdata : bus.if_rdata, ea.data);
          end
        end
        prev_ack = any_ack;
      end
    end
  end

  // One request, completed with bounded wait; req dropped in the ack cycle.
  task automatic run_req(input string nm, input logic dm, input logic we,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp_data, input int exp_lat,
                         input bit chk_stall);
    int start;
    bit got;
    iss_q.push_back('{addr: addr, we: we, wdata: wdata});
    ack_q.push_back('{dm: dm, data: exp_data});
    @(posedge clk);
    #2;
    start = cyc;
    if (dm) begin
      bus.dm_req = 1'b1; bus.dm_we = we; bus.dm_addr = addr; bus.dm_wdata = wdata;
    end else begin
      bus.if_req = 1'b1; bus.if_addr = addr;
    end
    got = 1'b0;
    for (int i = 0; i < 64 && !got; i++) begin
      @(negedge clk);
      if (dm ? bus.dm_ack : bus.if_ack) begin
        got = 1'b1;
        check({nm, "_latency"}, cyc - start, exp_lat);
        if (chk_stall) check({nm, "_stall_at_ack"}, {31'h0, bus.if_stall}, 32'h0);
        bus.if_req = 1'b0;
        bus.dm_req = 1'b0;
      end else if (chk_stall) begin
        check({nm, "_stall"}, {31'h0, bus.if_stall}, 32'h1);
      end
    end
    if (!got) begin
      checks++; failures++;
      $display("FAIL %s_timeout: got no ack, expected ack within 64 cycles", nm);
      bus.if_req = 1'b0;
      bus.dm_req = 1'b0;
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1);
  end

  initial begin
    int nacks;
    bus.if_req = 1'b0; bus.if_addr = 32'h0;
    bus.dm_req = 1'b0; bus.dm_we = 1'b0; bus.dm_addr = 32'h0; bus.dm_wdata = 32'h0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_mem_en", {31'h0, bus.mem_en}, 32'h0);
    check("rst_acks", {30'h0, bus.if_ack, bus.dm_ack}, 32'h0);
    check("rst_err", {31'h0, bus.err}, 32'h0);
    check("rst_mem_addr", bus.mem_addr, 32'h0);
    check("rst_if_rdata", bus.if_rdata, 32'h0);
    check("rst_dm_rdata", bus.dm_rdata, 32'h0);
    @(posedge clk);
    #2 rst = 1'b0;

    // IF-only read with minimum latency and stall profile
    resp_delay = 1; resp_data = 32'h8C220004;
    run_req("if_read", 1'b0, 1'b0, 32'h40, 32'h0, 32'h8C220004, 3, 1'b1);

    // DM load then DM store (store returns 0)
    resp_data = 32'h0000CAFE;
    run_req("dm_load", 1'b1, 1'b0, 32'h104, 32'h0, 32'h0000CAFE, 3, 1'b0);
    resp_data = 32'h77777777;
    run_req("dm_store", 1'b1, 1'b1, 32'h100, 32'h12345678, 32'h0, 3, 1'b0);
    check("if_rdata_hold", bus.if_rdata, 32'h8C220004);

    // Fairness: both held, expect DM x4 then IF, twice
    resp_delay = 1; resp_data = 32'h5A5A0001;
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 4; k++) begin
        iss_q.push_back('{addr: 32'h2000, we: 1'b0, wdata: 32'h0});
        ack_q.push_back('{dm: 1'b1, data: 32'h5A5A0001});
      end
      iss_q.push_back('{addr: 32'h1000, we: 1'b0, wdata: 32'h0});
      ack_q.push_back('{dm: 1'b0, data: 32'h5A5A0001});
    end
    @(posedge clk);
    #2;
    bus.if_addr = 32'h1000; bus.dm_addr = 32'h2000; bus.dm_we = 1'b0;
    bus.if_req = 1'b1; bus.dm_req = 1'b1;
    nacks = 0;
    for (int i = 0; i < 200 && nacks < 10; i++) begin
      @(negedge clk);
      if (bus.if_ack || bus.dm_ack) nacks++;
    end
    bus.if_req = 1'b0; bus.dm_req = 1'b0;
    check("fair_ack_count", nacks, 10);

    // Ready pulse during ISSUE is ignored; the later one is taken
    resp_delay = 0;
    @(posedge clk);
    #2;
    man_at0 = cyc + 2; man_dat0 = 32'h11111111;
    man_at1 = cyc + 4; man_dat1 = 32'hABCD0000;
    run_req("issue_pulse", 1'b1, 1'b0, 32'h440, 32'h0, 32'hABCD0000, 4, 1'b0);
    check("err_clear_before_timeout", {31'h0, bus.err}, 32'h0);

    // Timeout: no ready at all
    resp_delay = 0;
    run_req("timeout", 1'b0, 1'b0, 32'h80, 32'h0, 32'hDEADBEEF, 18, 1'b0);
    check("err_set", {31'h0, bus.err}, 32'h1);
    @(posedge clk);
    #2;
    man_at0 = cyc + 2; man_dat0 = 32'h33333333;
    repeat (5) @(negedge clk);
    check("err_sticky", {31'h0, bus.err}, 32'h1);
    check("late_ready_if_rdata", bus.if_rdata, 32'hDEADBEEF);

    // Async reset in the middle of a DM load WAIT
    iss_q.push_back('{addr: 32'h200, we: 1'b0, wdata: 32'h0});
    @(posedge clk);
    #2;
    bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 32'h200;
    repeat (5) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("arst_mem_en", {31'h0, bus.mem_en}, 32'h0);
    check("arst_acks", {30'h0, bus.if_ack, bus.dm_ack}, 32'h0);
    check("arst_err", {31'h0, bus.err}, 32'h0);
    check("arst_mem_addr", bus.mem_addr, 32'h0);
    check("arst_if_rdata", bus.if_rdata, 32'h0);
    check("arst_dm_rdata", bus.dm_rdata, 32'h0);
    bus.dm_req = 1'b0;
    @(posedge clk);
    #2 rst = 1'b0;
    resp_delay = 1; resp_data = 32'h0BADF00D;
    run_req("post_rst_if", 1'b0, 1'b0, 32'h300, 32'h0, 32'h0BADF00D, 3, 1'b1);

    repeat (6) @(negedge clk);
    check("iss_q_empty", iss_q.size(), 0);
    check("ack_q_empty", ack_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
